// File: rtl/sw_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sw_debounce_pkg
//   Shared constants for the switch conditioning stage that feeds the
//   Decoder's SW input.
//   - DEBOUNCE_DEFAULT : hold time of 10 ms at a 100 MHz system clock.
//   - DEBOUNCE_SIM     : short hold time for simulation.
//   - CNT_W_DEFAULT    : counter width that covers DEBOUNCE_DEFAULT.
//   - cnt_w_ok()       : returns 1 when a CNT_W-bit counter can reach
//                        DEBOUNCE-1.
// ---------------------------------------------------------------------------
package sw_debounce_pkg;

  localparam int unsigned CLK_HZ_DEFAULT   = 100_000_000;
  localparam int unsigned DEBOUNCE_MS      = 10;
  localparam int unsigned DEBOUNCE_DEFAULT = (CLK_HZ_DEFAULT / 1000) * DEBOUNCE_MS;
  localparam int unsigned DEBOUNCE_SIM     = 4;
  localparam int unsigned CNT_W_DEFAULT    = 20;

  // A CNT_W-bit counter holds 0 .. 2**CNT_W-1. It therefore reaches
  // DEBOUNCE-1 whenever 2**CNT_W >= DEBOUNCE.
  function automatic bit cnt_w_ok(input int unsigned debounce,
                                  input int unsigned cnt_w);
    if (cnt_w >= 32) return 1'b1;
    return (64'(1) << cnt_w) >= 64'(debounce);
  endfunction

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_if.sv
// ---------------------------------------------------------------------------
// sw_debounce_if
//   Bundles the switch-side and Decoder-side signals of the debouncer.
//   Signals:
//     sw_raw        : raw switch pins. They are asynchronous and may bounce.
//     SW            : debounced switch code.
//     sw_changed    : per-bit single-cycle strobe. A bit is high in the
//                     cycle that its bit accepted a new level.
//     sw_any_change : OR of sw_changed, in the same cycle.
//   Modports:
//     master : switch and board side. It drives sw_raw and observes the
//              outputs.
//     slave  : the debouncer. It consumes sw_raw and drives the outputs.
// ---------------------------------------------------------------------------
interface sw_debounce_if #(
  parameter int unsigned WIDTH = 2
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] sw_changed;
  logic             sw_any_change;

  modport master (
    output sw_raw,
    input  SW,
    input  sw_changed,
    input  sw_any_change
  );

  modport slave (
    input  sw_raw,
    output SW,
    output sw_changed,
    output sw_any_change
  );

endinterface : sw_debounce_if

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
//   Debounces a single switch bit.
//   - A 2-FF synchroniser (s1 -> s2) brings the asynchronous pin into the
//     clk domain.
//   - A hold counter measures how many consecutive cycles s2 has differed
//     from the accepted level.
//   - When the counter reaches DEBOUNCE-1 with s2 still different, the new
//     level is accepted and a one-cycle strobe is issued.
//   The FSM is implicit in cnt:
//     IDLE   : cnt == 0 and s2 == stable.
//     COUNT  : s2 != stable; a return to the old level drops back to IDLE.
//     ACCEPT : one cycle with the strobe high, then IDLE again.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous, active-high reset
//   raw     in   raw switch pin (asynchronous)
//   stable  out  accepted (debounced) level
//   changed out  registered strobe, high in the cycle that stable updated
//   accept  out  combinational "accept at the coming edge". It is derived
//                from flops only, so the top level can register the OR of
//                all bits in the same cycle as changed.
// ---------------------------------------------------------------------------
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic changed,
  output logic accept
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // The counter is saturated by construction: it clears on acceptance, so it
  // never passes CNT_LAST and cannot wrap.
  assign accept = (s2 != stable) && (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments, so s2 samples the
  // old s1 and the compare sees the pre-edge s2/stable/cnt -- exactly the
  // register pipeline the latency figures assume.
  always_ff @(posedge clk) begin
    if (rst) begin
      // A reset in the middle of a count simply drops the count. No strobe
      // is issued for the aborted count.
      s1      <= RESET_VAL;
      s2      <= RESET_VAL;
      stable  <= RESET_VAL;
      cnt     <= '0;
      changed <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        // Bounced back, or never left: restart the hold time.
        cnt     <= '0;
        changed <= 1'b0;
      end else if (cnt == CNT_LAST) begin
        stable  <= s2;
        cnt     <= '0;
        changed <= 1'b1;
      end else begin
        cnt     <= cnt + 1'b1;
        changed <= 1'b0;
      end
    end
  end

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//   Upstream conditioning for the switch-driven Decoder.
//   - Instantiates one sw_debounce_bit per switch; bits are independent.
//   - Forms a registered sw_any_change, which is high in the same cycle as
//     sw_changed.
//   - There is no combinational path from sw_raw to any output.
// Parameters:
//   WIDTH     number of switch bits
//   DEBOUNCE  consecutive cycles a new level must hold (>= 1)
//   RESET_VAL value of SW and of the synchroniser flops during reset
//   CNT_W     hold-counter width (2**CNT_W >= DEBOUNCE)
// Ports:
//   clk  in       system clock, rising edge
//   rst  in       synchronous, active-high reset
//   bus  slave    sw_raw in; SW, sw_changed, sw_any_change out
// ---------------------------------------------------------------------------
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned      WIDTH     = 2,
  parameter int unsigned      DEBOUNCE  = DEBOUNCE_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = CNT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  sw_debounce_if.slave   bus
);

  if (DEBOUNCE == 0 || !cnt_w_ok(DEBOUNCE, CNT_W)) begin : g_bad_param
    $error("sw_debounce: DEBOUNCE must be >= 1 and fit in CNT_W bits");
  end

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE  (DEBOUNCE),
      .CNT_W     (CNT_W),
      .RESET_VAL (RESET_VAL[i])
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .raw     (bus.sw_raw[i]),
      .stable  (bus.SW[i]),
      .changed (bus.sw_changed[i]),
      .accept  (accept[i])
    );
  end

  // The per-bit accept terms are registered here. This puts
  // sw_any_change in the same cycle as the per-bit changed flops, instead
  // of a combinational OR behind them.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sw_any_change <= 1'b0;
    end else begin
      bus.sw_any_change <= |accept;
    end
  end

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
//   Directed scenarios followed by randomized switch activity.
//   The reference model describes the debouncer in terms of when a level
//   started to disagree with the accepted code. A new level is accepted once
//   the synchronised level has disagreed for DEBOUNCE consecutive edges.
//   Expected outputs are queued per edge and compared by a separate monitor
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_sw_debounce;
  import sw_debounce_pkg::*;

  localparam int unsigned      W  = 2;
  localparam int unsigned      D  = DEBOUNCE_SIM;
  localparam logic [W-1:0]     RV = '0;

  typedef struct packed {
    logic [W-1:0] sw;
    logic [W-1:0] ch;
    logic         any;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sw_debounce_if #(.WIDTH(W)) bus ();

  sw_debounce #(
    .WIDTH     (W),
    .DEBOUNCE  (D),
    .RESET_VAL (RV),
    .CNT_W     (CNT_W_DEFAULT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the synchroniser is a plain two-entry delay line of
  // samples. Debouncing is tracked as "edge index at which disagreement
  // began"; acceptance happens when the disagreement span reaches D edges.
  initial begin : model
    logic [W-1:0] p1, p2, st, syn, ch;
    int start [W];
    int e;
    p1 = RV; p2 = RV; st = RV; e = 0;
    for (int i = 0; i < int'(W); i++) start[i] = -1;
    forever begin
      @(posedge clk);
      e++;
      ch = '0;
      if (rst) begin
        p1 = RV; p2 = RV; st = RV;
        for (int i = 0; i < int'(W); i++) start[i] = -1;
      end else begin
        syn = p2;
        p2  = p1;
        p1  = bus.sw_raw;
        for (int i = 0; i < int'(W); i++) begin
          if (syn[i] == st[i]) begin
            start[i] = -1;
          end else begin
            if (start[i] < 0) start[i] = e;
            if (e - start[i] + 1 >= int'(D)) begin
              st[i]    = syn[i];
              ch[i]    = 1'b1;
              start[i] = -1;
            end
          end
        end
      end
      q.push_back('{sw: st, ch: ch, any: |ch});
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        check("SW",            32'(bus.SW),            32'(x.sw));
        check("sw_changed",    32'(bus.sw_changed),    32'(x.ch));
        check("sw_any_change", 32'(bus.sw_any_change), 32'(x.any));
      end
    end
  end

  // Hold a raw value for n edges. On return, inputs may change away from
  // the edge.
  task automatic drive(input logic [W-1:0] v, input int n);
    bus.sw_raw = v;
    repeat (n) @(posedge clk);
    #4;
  endtask

  // Count edges after the current point until SW reaches want, bounded.
  task automatic latency(input string name, input logic [W-1:0] want, input int exp_edges);
    int found;
    found = 0;
    for (int k = 1; k <= 12 && found == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.SW == want) found = k;
    end
    check(name, 32'(found), 32'(exp_edges));
  endtask

  initial begin : stim
    logic [W-1:0] seq [5];
    logic [W-1:0] v;
    int           n;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd2;

    // 1: raw 11 through reset; accepted 6 edges after release.
    bus.sw_raw = 2'b11;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #4 rst = 1'b0;
    latency("release_latency", 2'b11, 6);
    drive(2'b11, 3);

    // 2: back to 00, then 00 -> 01.
    drive(2'b00, 10);
    bus.sw_raw = 2'b01;
    latency("bit0_latency", 2'b01, 6);
    drive(2'b01, 3);

    // 3: bit0 toggling every 2 cycles must be discarded.
    drive(2'b00, 10);
    for (int k = 0; k < 10; k++) drive(2'(k % 2 == 0 ? 2'b01 : 2'b00), 2);
    drive(2'b00, 10);

    // 4: 3-cycle pulse ignored, 4-cycle pulse accepted, release accepted.
    drive(2'b10, 3);
    drive(2'b00, 8);
    drive(2'b10, 4);
    drive(2'b00, 12);

    // 5: reset two cycles into a 01 -> 11 count.
    drive(2'b01, 10);
    bus.sw_raw = 2'b11;
    repeat (2) @(posedge clk);
    #4 rst = 1'b1;
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    latency("reset_abort_latency", 2'b11, 6);
    drive(2'b11, 3);

    // 6: code sequence into the Decoder, 8 cycles per step.
    drive(2'b00, 10);
    for (int k = 0; k < 5; k++) drive(seq[k], 8);

    // Randomized holds, occasional short resets.
    repeat (120) begin
      v = 2'($urandom_range(0, 3));
      n = int'($urandom_range(1, 9));
      if ($urandom_range(0, 24) == 0) begin
        #1 rst = 1'b1;
        drive(v, int'($urandom_range(1, 2)));
        rst = 1'b0;
      end else begin
        drive(v, n);
      end
    end
    drive(2'b00, 10);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sw_debounce
